alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Small registered integer ALU: two unsigned WIDTH-bit operands, 3-bit opcode, 2*WIDTH-bit result.
- Eight operations: add, multiply, modulo, AND, OR, XOR, subtract, divide.
- Sits as a leaf datapath block; the result is registered with one-cycle latency and a valid strobe.

Parameters:
- WIDTH, 4, operand width in bits; result width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- op  input  3  opcode
- out_valid  output  1  res holds a new result
- res  output  2*WIDTH  registered result
- div_zero  output  1  set with out_valid when op is MOD/DIV and b==0

Behaviour:
- Reset (rst_n low, asynchronous): res=0, out_valid=0, div_zero=0. Release is synchronous to clk.
- Latency: in_valid sampled at a rising edge; on the next edge res, out_valid=1 and div_zero update.
- in_valid=0 at an edge: out_valid goes 0; res and div_zero hold their previous values.
- No backpressure: a new operation may be accepted every cycle. Back-to-back results appear on consecutive cycles.
- Opcodes; operands are zero-extended to 2*WIDTH before the operation:
  - 0 ADD: a+b. Maximum 30 for WIDTH=4; never overflows.
  - 1 MUL: a*b, full product. Maximum 225.
  - 2 MOD: a%b. If b==0: res=a zero-extended, div_zero=1.
  - 3 AND: a&b, upper WIDTH bits 0.
  - 4 OR: a|b, upper bits 0.
  - 5 XOR: a^b, upper bits 0.
  - 6 SUB: a-b as 2*WIDTH-bit two's complement. Example: 2-3 gives 8'hFF.
  - 7 DIV: a/b, truncated. If b==0: res = all ones, div_zero=1.
- div_zero is 0 for all other opcodes and for MOD/DIV with b!=0.
- Reset asserted mid-operation: the in-flight result is discarded and outputs clear immediately.
- X/Z on op is not handled; any op value is one of 0..7 by construction.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: adds outputs zero (1-bit, res==0) and neg (1-bit, res MSB, meaningful for SUB). Both are registered alongside res, reset to 0, and hold when in_valid=0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode enum alu_op_e: OP_ADD=0, OP_MUL=1, OP_MOD=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_SUB=6, OP_DIV=7;
  - constant DIV0_RES (all ones).
- One natural sub-module: alu_divmod, a combinational unsigned divider producing quotient, remainder and div_zero. The top holds the opcode mux and output registers.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_valid=1 -> res=0, out_valid=0, div_zero=0 immediately; first result appears one cycle after release.
- Arithmetic: ADD (2,3)->5, (15,15)->30; MUL (3,4)->12, (10,9)->90, (15,15)->225; SUB (2,3)->0xFF, (10,9)->1, (15,15)->0.
- Logic: AND (10,9)->8, (3,4)->0; OR (10,9)->11, (2,3)->3; XOR (10,9)->3, (15,15)->0. Upper nibble is 0 in all cases.
- Divide/modulo: MOD (10,9)->1, (3,4)->3, (15,15)->0; DIV (10,9)->1, (3,4)->0, (15,15)->1. div_zero=0 throughout.
- Divide by zero: MOD (7,0) -> res=7, div_zero=1; DIV (7,0) -> res=0xFF, div_zero=1; next ADD (1,1) -> res=2, div_zero=0.
- Throughput/hold: sweep all 8 ops on consecutive cycles with in_valid=1 -> one result per cycle, each one cycle late. Then in_valid=0 -> out_valid=0 and res holds its last value.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and constants for the alu_core datapath.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_MUL = 3'd1,
    OP_MOD = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SUB = 3'd6,
    OP_DIV = 3'd7
  } alu_op_e;

  // Wide enough for any result width; users take the low bits they need.
  localparam logic [63:0] DIV0_RES = '1;

endpackage

// File: rtl/alu_divmod.sv
// Combinational unsigned restoring divider: quotient, remainder, divide-by-zero flag.
module alu_divmod #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  logic [WIDTH:0] acc;

  // One restoring step per quotient bit, MSB first; b==0 falls out as quo=all ones, rem=a.
  always_comb begin
    acc = '0;
    quo = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc = {acc[WIDTH-1:0], a[i]};
      if (acc >= {1'b0, b}) begin
        acc    = acc - {1'b0, b};
        quo[i] = 1'b1;
      end
    end
  end

  assign rem      = acc[WIDTH-1:0];
  assign div_zero = (b == '0);

endmodule

// File: rtl/alu_core.sv
// Registered 8-op integer ALU, one-cycle latency. Optional zero/neg flags under ALU_FLAGS_EN.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] res,
  output logic               div_zero
`ifdef ALU_FLAGS_EN
  ,
  output logic               zero,
  output logic               neg
`endif
);

  localparam int RW = 2 * WIDTH;

  logic [RW-1:0]    a_x, b_x, res_nxt;
  logic [WIDTH-1:0] quo, rem;
  logic             dz, dz_nxt;

  assign a_x = {{WIDTH{1'b0}}, a};
  assign b_x = {{WIDTH{1'b0}}, b};

  alu_divmod #(.WIDTH(WIDTH)) u_divmod (
    .a        (a),
    .b        (b),
    .quo      (quo),
    .rem      (rem),
    .div_zero (dz)
  );

  always_comb begin
    res_nxt = '0;
    dz_nxt  = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: res_nxt = a_x + b_x;
      OP_MUL: res_nxt = a_x * b_x;
      OP_MOD: begin
        res_nxt = dz ? a_x : {{WIDTH{1'b0}}, rem};
        dz_nxt  = dz;
      end
      OP_AND: res_nxt = a_x & b_x;
      OP_OR:  res_nxt = a_x | b_x;
      OP_XOR: res_nxt = a_x ^ b_x;
      OP_SUB: res_nxt = a_x - b_x;
      OP_DIV: begin
        res_nxt = dz ? DIV0_RES[RW-1:0] : {{WIDTH{1'b0}}, quo};
        dz_nxt  = dz;
      end
      default: res_nxt = '0;
    endcase
  end

  // Result and flags only move on an accepted op; out_valid pulses per op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      div_zero  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res      <= res_nxt;
        div_zero <= dz_nxt;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      neg  <= 1'b0;
    end else if (in_valid) begin
      zero <= (res_nxt == '0);
      neg  <= res_nxt[RW-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed plan vectors plus randomized ops vs. an arithmetic model.
module tb_alu_core;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = '0;
  logic          out_valid;
  logic [RW-1:0] res;
  logic          div_zero;
`ifdef ALU_FLAGS_EN
  logic          zero, neg;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  logic [RW-1:0] m_res = '0;
  logic          m_dz = 1'b0;
  logic          m_vld = 1'b0;
  logic          m_zero = 1'b0;
  logic          m_neg = 1'b0;

  alu_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .res       (res),
    .div_zero  (div_zero)
`ifdef ALU_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg)
`endif
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic modulo 2^(2W), straight from the opcode table.
  function automatic void calc(input int o, input int x, input int y,
                               output logic [RW-1:0] r, output logic dz);
    int m, v;
    m  = 1 << RW;
    dz = 1'b0;
    case (o)
      0: v = x + y;
      1: v = x * y;
      2: begin if (y == 0) begin v = x; dz = 1'b1; end else v = x % y; end
      3: v = x & y;
      4: v = x | y;
      5: v = x ^ y;
      6: v = (x - y + m) % m;
      default: begin if (y == 0) begin v = m - 1; dz = 1'b1; end else v = x / y; end
    endcase
    r = v[RW-1:0];
  endfunction

  // Drive one cycle from a falling edge; model advances as the DUT should.
  task automatic drive(input logic v, input int o, input int x, input int y);
    logic [RW-1:0] r;
    logic dz;
    in_valid = v;
    op = o[2:0];
    a  = x[W-1:0];
    b  = y[W-1:0];
    @(negedge clk);
    m_vld = v;
    if (v) begin
      calc(o, x, y, r, dz);
      m_res  = r;
      m_dz   = dz;
      m_zero = (r == '0);
      m_neg  = r[RW-1];
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if (res !== '0 || out_valid !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: res=%0h vld=%0b dz=%0b expected 0/0/0", res, out_valid, div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 0, 15, 15);
    checks++;
    if (res !== 8'd30 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: res=%0h vld=%0b expected 1e/1", res, out_valid);
    end
    // reset mid-stream with a new op presented
    in_valid = 1'b1; op = 3'd1; a = 4'd15; b = 4'd15;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (res !== '0 || out_valid !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: res=%0h vld=%0b dz=%0b expected 0/0/0", res, out_valid, div_zero);
    end
    @(negedge clk);
    checks++;
    if (res !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: res=%0h vld=%0b expected 0/0", res, out_valid);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if (zero !== 1'b0 || neg !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: zero=%0b neg=%0b expected 0/0", zero, neg);
    end
`endif
    m_res = '0; m_dz = 1'b0; m_vld = 1'b0; m_zero = 1'b0; m_neg = 1'b0;
    rst_n = 1'b1;
    drive(1'b1, 0, 2, 3);
    checks++;
    if (res !== 8'd5 || out_valid !== 1'b1 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_first: res=%0h vld=%0b dz=%0b expected 5/1/0", res, out_valid, div_zero);
    end
  endtask

  // Directed vectors: {op, a, b, expected res, expected div_zero}
  task automatic test_directed;
    int tbl[23][5] = '{
      '{0, 2, 3, 5, 0},    '{0, 15, 15, 30, 0},
      '{1, 3, 4, 12, 0},   '{1, 10, 9, 90, 0},   '{1, 15, 15, 225, 0},
      '{6, 2, 3, 255, 0},  '{6, 10, 9, 1, 0},    '{6, 15, 15, 0, 0},
      '{3, 10, 9, 8, 0},   '{3, 3, 4, 0, 0},
      '{4, 10, 9, 11, 0},  '{4, 2, 3, 3, 0},
      '{5, 10, 9, 3, 0},   '{5, 15, 15, 0, 0},
      '{2, 10, 9, 1, 0},   '{2, 3, 4, 3, 0},     '{2, 15, 15, 0, 0},
      '{7, 10, 9, 1, 0},   '{7, 3, 4, 0, 0},     '{7, 15, 15, 1, 0},
      '{2, 7, 0, 7, 1},    '{7, 7, 0, 255, 1},   '{0, 1, 1, 2, 0}
    };
    for (int i = 0; i < 23; i++) begin
      drive(1'b1, tbl[i][0], tbl[i][1], tbl[i][2]);
      checks++;
      if (res !== tbl[i][3][RW-1:0] || div_zero !== tbl[i][4][0] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL directed[%0d] op=%0d a=%0d b=%0d: res=%0h dz=%0b vld=%0b expected %0h/%0b/1",
                 i, tbl[i][0], tbl[i][1], tbl[i][2], res, div_zero, out_valid,
                 tbl[i][3], tbl[i][4]);
      end
    end
  endtask

  // All eight ops back-to-back, then idle cycles that must hold the last result.
  task automatic test_back_to_back;
    logic [RW-1:0] last;
    logic          last_dz;
    for (int o = 0; o < 8; o++) begin
      drive(1'b1, o, $urandom_range(0, 15), $urandom_range(0, 15));
      checks++;
      if (out_valid !== 1'b1 || res !== m_res || div_zero !== m_dz) begin
        errors++;
        $display("FAIL b2b op=%0d: res=%0h dz=%0b vld=%0b expected %0h/%0b/1",
                 o, res, div_zero, out_valid, m_res, m_dz);
      end
    end
    last = m_res;
    last_dz = m_dz;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
      checks++;
      if (out_valid !== 1'b0 || res !== last || div_zero !== last_dz) begin
        errors++;
        $display("FAIL hold[%0d]: res=%0h dz=%0b vld=%0b expected %0h/%0b/0",
                 i, res, div_zero, out_valid, last, last_dz);
      end
    end
  endtask

  // Random ops with random idle gaps, b biased toward zero.
  task automatic test_random;
    int x, y;
    for (int i = 0; i < 300; i++) begin
      x = $urandom_range(0, 15);
      y = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15);
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 7), x, y);
      checks++;
      if (out_valid !== m_vld || res !== m_res || div_zero !== m_dz) begin
        errors++;
        $display("FAIL random[%0d]: res=%0h dz=%0b vld=%0b expected %0h/%0b/%0b",
                 i, res, div_zero, out_valid, m_res, m_dz, m_vld);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (zero !== m_zero || neg !== m_neg) begin
        errors++;
        $display("FAIL flags[%0d]: zero=%0b neg=%0b expected %0b/%0b", i, zero, neg, m_zero, m_neg);
      end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
